jesd_sysref_gen: RTL and testbench



---
 rtl/jesd_sysref_pkg.sv | 17 +
 rtl/jesd_sysref_if.sv | 31 +++
 rtl/jesd_sysref_gen_sync_debounce.sv | 42 ++++
 rtl/jesd_sysref_gen.sv | 128 ++++++++++++
 tb/tb_jesd_sysref_gen.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/jesd_sysref_pkg.sv
// Shared types for the JESD204B SYSREF / LMFC generator.
// FSM state encoding and sequence-mode constants.
package jesd_sysref_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_CONT  = 2'b01;
  localparam logic [1:0] MODE_NSHOT = 2'b10;
  localparam logic [1:0] MODE_GATED = 2'b11;

endpackage

// File: rtl/jesd_sysref_if.sv
// Control/status bundle of the SYSREF generator.
// master drives requests, slave is the generator.
interface jesd_sysref_if #(
  parameter int CNT_W = 12
);

  logic [CNT_W-1:0] period;
  logic [1:0]       mode;
  logic [7:0]       shot_count;
  logic             start;
  logic             stop;
  logic             sysref;
  logic             lmfc_tick;
  logic             busy;
  logic             done;
  logic [7:0]       pulses_sent;
  logic             sync_ok;

  modport master (
    output period, mode, shot_count, start, stop,
    input  sysref, lmfc_tick, busy, done,
    input  pulses_sent, sync_ok
  );

  modport slave (
    input  period, mode, shot_count, start, stop,
    output sysref, lmfc_tick, busy, done,
    output pulses_sent, sync_ok
  );

endinterface

// File: rtl/jesd_sysref_gen_sync_debounce.sv
// SYNC~ synchronizer with a consecutive-high stability filter.
// stable_hi drops on the first synchronized low sample.
module sync_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 4
) (
  input  logic clk_160MHz,
  input  logic rst_n,
  input  logic async_in,
  output logic stable_hi
);

  localparam int CW = $clog2(STABLE_CYC + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   w_s;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign stable_hi = r_stable;

  always_ff @(posedge clk_160MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      if (!w_s) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else begin
        if (r_cnt != CW'(STABLE_CYC))
          r_cnt <= r_cnt + 1'b1;
        if (r_cnt >= CW'(STABLE_CYC - 1))
          r_stable <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/jesd_sysref_gen.sv
// JESD204B SYSREF strobe and LMFC tick generator.
// Continuous, N-shot and SYNC~-gated sequences.
module jesd_sysref_gen
  import jesd_sysref_pkg::*;
#(
  parameter int CNT_W       = 12,
  parameter int DEF_PERIOD  = 64,
  parameter int HIGH_CYCLES = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 4
) (
  input  logic          clk_160MHz,
  input  logic          rst_n,
  input  logic          sync_n,
  jesd_sysref_if.slave  bus
);

  localparam logic [CNT_W-1:0] HI    = CNT_W'(HIGH_CYCLES);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(2 * HIGH_CYCLES);
  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] w_phase_nxt;
  logic [CNT_W-1:0] r_period;
  logic [1:0]       r_mode;
  logic [7:0]       r_shot;
  logic [7:0]       r_pulses;
  logic [7:0]       w_cnt_inc;
  logic             r_stop_pend;
  logic             r_sysref;
  logic             r_tick;
  logic             w_sync_ok;
  logic             w_start_ok;
  logic             w_wrap;
  logic             w_pulse_end;
  logic             w_term;

  sync_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .STABLE_CYC  (STABLE_CYC)
  ) u_sync (
    .clk_160MHz (clk_160MHz),
    .rst_n      (rst_n),
    .async_in   (sync_n),
    .stable_hi  (w_sync_ok)
  );

  assign w_start_ok  = bus.start && (r_state == S_IDLE)
                    && (bus.mode != MODE_OFF);
  assign w_wrap      = (r_phase == r_period - 1'b1);
  assign w_pulse_end = (r_state == S_RUN) && (r_phase == HI - 1'b1);
  assign w_cnt_inc   = (r_pulses == 8'hFF) ? r_pulses
                                           : r_pulses + 8'd1;

  // Stop seen this cycle counts as pending so it is never lost.
  assign w_term = ((r_mode == MODE_NSHOT) && (w_cnt_inc == r_shot))
               || ((r_mode == MODE_GATED) && w_sync_ok)
               || r_stop_pend || bus.stop;

  always_comb begin
    w_phase_nxt = r_phase + 1'b1;
    if (w_start_ok || w_wrap)
      w_phase_nxt = '0;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_start_ok)
          w_state_nxt = S_ARM;
      S_ARM:
        if (bus.stop)
          w_state_nxt = S_IDLE;
        else if (w_wrap)
          w_state_nxt = ((r_mode == MODE_NSHOT) && (r_shot == 8'd0))
                      ? S_DONE : S_RUN;
      S_RUN:
        if (w_pulse_end && w_term)
          w_state_nxt = S_DONE;
      S_DONE:
        w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_160MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_period    <= DEF_P;
      r_mode      <= MODE_OFF;
      r_shot      <= '0;
      r_pulses    <= '0;
      r_stop_pend <= 1'b0;
      r_sysref    <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_tick   <= (w_phase_nxt == '0);
      r_sysref <= (r_state == S_RUN) && (r_phase < HI);
      if (w_start_ok) begin
        r_mode   <= bus.mode;
        r_shot   <= bus.shot_count;
        r_period <= (bus.period < MIN_P) ? MIN_P : bus.period;
        r_pulses <= '0;
      end else if (w_pulse_end) begin
        r_pulses <= w_cnt_inc;
      end
      if (r_state == S_IDLE)
        r_stop_pend <= 1'b0;
      else if ((r_state == S_RUN) && bus.stop)
        r_stop_pend <= 1'b1;
    end
  end

  assign bus.sysref      = r_sysref;
  assign bus.lmfc_tick   = r_tick;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.pulses_sent = r_pulses;
  assign bus.sync_ok     = w_sync_ok;

endmodule

// File: tb/tb_jesd_sysref_gen.sv
// Directed bench for jesd_sysref_gen.
// Hand-computed expectations, immediate assertions.
module tb_jesd_sysref_gen;
  import jesd_sysref_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sync_n = 1'b0;

  jesd_sysref_if #(.CNT_W(12)) bus ();

  jesd_sysref_gen dut (
    .clk_160MHz (clk),
    .rst_n      (rst_n),
    .sync_n     (sync_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int   cyc, nrise, nfall, ndone, npass, ntot;
  int   rise_c[64];
  int   fall_c[64];
  logic prev, okseen;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.sysref && !prev) begin
      if (nrise < 64) rise_c[nrise] = cyc;
      nrise++;
    end
    if (!bus.sysref && prev) begin
      if (nfall < 64) fall_c[nfall] = cyc;
      nfall++;
    end
    if (bus.done) ndone++;
    if (bus.sync_ok) okseen = 1'b1;
    prev = bus.sysref;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic clr();
    nrise = 0; nfall = 0; ndone = 0; okseen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rise_c[i] = 0; fall_c[i] = 0;
    end
  endtask

  task automatic go(input logic [11:0] p, input logic [1:0] m,
                    input logic [7:0] s, output int sc);
    bus.period = p; bus.mode = m; bus.shot_count = s;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    sc = cyc;
  endtask

  task automatic wait_rises(input int n, input int lim);
    int k;
    k = 0;
    while (nrise < n && k < lim) begin step(); k++; end
    chk("wait_rise", 32'(nrise >= n), 1);
  endtask

  task automatic wait_done(input int lim);
    int k;
    k = 0;
    while (ndone < 1 && k < lim) begin step(); k++; end
    chk("wait_done", 32'(ndone >= 1), 1);
  endtask

  task automatic tick_gap(output int g);
    int k, a;
    g = 0; k = 0;
    while (!bus.lmfc_tick && k < 200) begin step(); k++; end
    a = cyc;
    step();
    k = 0;
    while (!bus.lmfc_tick && k < 200) begin step(); k++; end
    if (bus.lmfc_tick) g = cyc - a;
  endtask

  initial begin
    int s, g, base, f0, k;
    cyc = 0; npass = 0; ntot = 0; prev = 1'b0;
    bus.period = '0; bus.mode = MODE_OFF; bus.shot_count = '0;
    bus.start = 1'b0; bus.stop = 1'b0;
    clr();

    // reset values
    steps(3);
    chk("rst_sysref", 32'(bus.sysref), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_pulses", 32'(bus.pulses_sent), 0);
    chk("rst_sync_ok", 32'(bus.sync_ok), 0);
    chk("rst_tick", 32'(bus.lmfc_tick), 0);
    rst_n = 1'b1;
    tick_gap(g);
    chk("def_tick_gap", g, 64);

    // N-shot, 3 pulses at period 16
    clr();
    go(12'd16, MODE_NSHOT, 8'd3, s);
    chk("ns_busy", 32'(bus.busy), 1);
    steps(80);
    chk("ns_first_rise", rise_c[0] - s, 17);
    chk("ns_gap1", rise_c[1] - rise_c[0], 16);
    chk("ns_gap2", rise_c[2] - rise_c[1], 16);
    for (int i = 0; i < 3; i++)
      chk("ns_width", fall_c[i] - rise_c[i], 4);
    chk("ns_rises", nrise, 3);
    chk("ns_done", ndone, 1);
    chk("ns_pulses", 32'(bus.pulses_sent), 3);
    chk("ns_busy_end", 32'(bus.busy), 0);

    // continuous, ignored second start, stop in 2nd pulse
    clr();
    go(12'd32, MODE_CONT, 8'd0, s);
    wait_rises(1, 100);
    bus.period = 12'd8; bus.mode = MODE_NSHOT; bus.shot_count = 8'd1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_rises(2, 100);
    step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    wait_done(100);
    steps(5);
    chk("cs_gap", rise_c[1] - rise_c[0], 32);
    chk("cs_width2", fall_c[1] - rise_c[1], 4);
    chk("cs_rises", nrise, 2);
    chk("cs_pulses", 32'(bus.pulses_sent), 2);
    chk("cs_done", ndone, 1);
    chk("cs_busy", 32'(bus.busy), 0);

    // period clamp: 3 -> 8
    clr();
    go(12'd3, MODE_CONT, 8'd0, s);
    wait_rises(3, 100);
    chk("cl_gap1", rise_c[1] - rise_c[0], 8);
    chk("cl_gap2", rise_c[2] - rise_c[1], 8);
    tick_gap(g);
    chk("cl_tick_gap", g, 8);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    wait_done(50);
    steps(2);
    chk("cl_busy", 32'(bus.busy), 0);

    // N-shot with zero shots
    clr();
    go(12'd16, MODE_NSHOT, 8'd0, s);
    steps(40);
    chk("z_rises", nrise, 0);
    chk("z_done", ndone, 1);
    chk("z_pulses", 32'(bus.pulses_sent), 0);
    chk("z_busy", 32'(bus.busy), 0);

    // start with mode off
    clr();
    go(12'd16, MODE_OFF, 8'd5, s);
    chk("off_busy", 32'(bus.busy), 0);
    steps(20);
    chk("off_busy2", 32'(bus.busy), 0);
    chk("off_done", ndone, 0);
    chk("off_rises", nrise, 0);

    // sync-gated with a short glitch on SYNC~
    clr();
    go(12'd16, MODE_GATED, 8'd0, s);
    steps(100);
    sync_n = 1'b1;
    steps(2);
    sync_n = 1'b0;
    steps(8);
    chk("g_glitch_ok", 32'(okseen), 0);
    chk("g_through", 32'(nrise >= 6), 1);
    f0 = nfall; k = 0;
    while (nfall == f0 && k < 40) begin step(); k++; end
    chk("g_wait_fall", 32'(nfall > f0), 1);
    sync_n = 1'b1;
    base = nrise;
    steps(5);
    chk("g_ok_early", 32'(bus.sync_ok), 0);
    step();
    chk("g_ok_rise", 32'(bus.sync_ok), 1);
    wait_done(100);
    steps(2);
    chk("g_last_pulse", nrise - base, 1);
    chk("g_pulses", 32'(bus.pulses_sent), nrise);
    chk("g_sync_ok", 32'(bus.sync_ok), 1);
    chk("g_busy", 32'(bus.busy), 0);

    // reset in the middle of a pulse
    clr();
    go(12'd16, MODE_CONT, 8'd0, s);
    wait_rises(2, 100);
    step();
    chk("mr_pre_sysref", 32'(bus.sysref), 1);
    chk("mr_pre_pulses", 32'(bus.pulses_sent), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_sysref", 32'(bus.sysref), 0);
    chk("mr_busy", 32'(bus.busy), 0);
    chk("mr_pulses", 32'(bus.pulses_sent), 0);
    steps(2);
    rst_n = 1'b1;
    clr();
    tick_gap(g);
    chk("mr_tick_gap", g, 64);
    chk("mr_busy_after", 32'(bus.busy), 0);
    chk("mr_no_rise", nrise, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
